// File: rtl/csi2tx_ahb_resp_mux.sv
// rtl/csi2tx_ahb_resp_mux.sv - AHB data-phase response mux for three slaves; CSI2TX_AHB_DEFAULT_SLAVE_EN swaps slave 3 for an internal error-returning default slave
module csi2tx_ahb_resp_mux (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        hsel1,
  input  logic        hsel2,
  input  logic        hsel3,
  input  logic [1:0]  htrans,
  input  logic [31:0] hrdata_s1,
  input  logic [31:0] hrdata_s2,
  input  logic [31:0] hrdata_s3,
  input  logic        hreadyout_s1,
  input  logic        hreadyout_s2,
  input  logic        hreadyout_s3,
  input  logic [1:0]  hresp_s1,
  input  logic [1:0]  hresp_s2,
  input  logic [1:0]  hresp_s3,
  output logic [31:0] hrdata,
  output logic        hready,
  output logic [1:0]  hresp
);

  // One-hot data-phase select codes; 000 means no slave owns the data phase.
  localparam logic [2:0] SEL_NONE = 3'b000;
  localparam logic [2:0] SEL_S1   = 3'b001;
  localparam logic [2:0] SEL_S2   = 3'b010;
  localparam logic [2:0] SEL_S3   = 3'b100;

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  logic [2:0]  sel_q;
  logic [2:0]  sel_d;

  // Response seen on the slave-3 leg: either the external slave or the default slave.
  logic [31:0] s3_rdata;
  logic        s3_ready;
  logic [1:0]  s3_resp;

  // Address-phase priority encode: hsel2 beats hsel1 beats hsel3.
  always_comb begin
    sel_d = SEL_NONE;
    if (hsel2) begin
      sel_d = SEL_S2;
    end else if (hsel1) begin
      sel_d = SEL_S1;
    end else if (hsel3) begin
      sel_d = SEL_S3;
    end
  end

  // Data-phase owner advances only on hready edges; a wait state holds the owner.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      sel_q <= SEL_NONE;
    end else if (hready) begin
      sel_q <= sel_d;
    end
  end

`ifdef CSI2TX_AHB_DEFAULT_SLAVE_EN
  // Default slave answers every NONSEQ/SEQ with the two-cycle AHB ERROR response.
  localparam logic [1:0] DS_IDLE = 2'b00;
  localparam logic [1:0] DS_ERR1 = 2'b01;
  localparam logic [1:0] DS_ERR2 = 2'b10;

  logic [1:0] ds_state_q;
  logic [1:0] ds_state_d;
  logic       ds_start;

  // The external slave-3 port is dead in this build, and only htrans[1] matters.
  logic unused_s3;
  assign unused_s3 = ^{hrdata_s3, hreadyout_s3, hresp_s3, htrans[0]};

  // IDLE/BUSY transfers still select the default slave but never start an error.
  assign ds_start = hready && (sel_d == SEL_S3) && htrans[1];

  // Next-state logic: a newly accepted active transfer always restarts the error.
  always_comb begin
    ds_state_d = DS_IDLE;
    if (ds_start) begin
      ds_state_d = DS_ERR1;
    end else begin
      case (ds_state_q)
        DS_ERR1: ds_state_d = DS_ERR2;
        DS_ERR2: ds_state_d = DS_IDLE;
        default: ds_state_d = DS_IDLE;
      endcase
    end
  end

  // Default-slave state register.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      ds_state_q <= DS_IDLE;
    end else begin
      ds_state_q <= ds_state_d;
    end
  end

  // ERR1 stalls with ERROR, ERR2 completes with ERROR, idle is a zero-wait OKAY.
  always_comb begin
    s3_rdata = 32'h0;
    s3_ready = 1'b1;
    s3_resp  = RESP_OKAY;
    case (ds_state_q)
      DS_ERR1: begin
        s3_ready = 1'b0;
        s3_resp  = RESP_ERROR;
      end
      DS_ERR2: begin
        s3_ready = 1'b1;
        s3_resp  = RESP_ERROR;
      end
      default: begin
        s3_ready = 1'b1;
        s3_resp  = RESP_OKAY;
      end
    endcase
  end
`else
  // Without the default slave the transfer type has no effect on routing.
  logic unused_htrans;
  assign unused_htrans = ^htrans;

  // Slave-3 leg is a straight pass-through of the external slave.
  always_comb begin
    s3_rdata = hrdata_s3;
    s3_ready = hreadyout_s3;
    s3_resp  = hresp_s3;
  end
`endif

  // Zero-latency output mux; an unowned data phase reads as a ready OKAY with zero data.
  always_comb begin
    hrdata = 32'h0;
    hready = 1'b1;
    hresp  = RESP_OKAY;
    case (sel_q)
      SEL_S1: begin
        hrdata = hrdata_s1;
        hready = hreadyout_s1;
        hresp  = hresp_s1;
      end
      SEL_S2: begin
        hrdata = hrdata_s2;
        hready = hreadyout_s2;
        hresp  = hresp_s2;
      end
      SEL_S3: begin
        hrdata = s3_rdata;
        hready = s3_ready;
        hresp  = s3_resp;
      end
      default: begin
        hrdata = 32'h0;
        hready = 1'b1;
        hresp  = RESP_OKAY;
      end
    endcase
  end

endmodule

// File: doc/csi2tx_ahb_resp_mux.md
CSI2TX_AHB_RESP_MUX -- requirements
Module: csi2tx_ahb_resp_mux

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named as below.
- hclk  input  1  system clock; all state on rising edge.
- hresetn  input  1  asynchronous active-low reset.
REQ-002 The decoder, bus and slave-response ports SHALL be exactly:
- hsel1, hsel2, hsel3  input  1 each  address-phase slave selects from the address decoder.
- htrans  input  2  master transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- hrdata_s1, hrdata_s2, hrdata_s3  input  32 each  slave read data.
- hreadyout_s1, hreadyout_s2, hreadyout_s3  input  1 each  slave ready.
- hresp_s1, hresp_s2, hresp_s3  input  2 each  slave response: 00 OKAY, 01 ERROR.
- hrdata  output  32  muxed read data to the master.
- hready  output  1  muxed ready to the master; also fed back to all slaves.
- hresp  output  2  muxed response to the master.

Function
REQ-003 A 3-bit one-hot data-phase select register sel_q SHALL load on the rising hclk edge only when hready=1.
REQ-004 When sel_q loads and more than one hsel is high, priority SHALL be hsel2 > hsel1 > hsel3; only the winning bit is set.
REQ-005 When sel_q loads and no hsel is high, sel_q SHALL load 000.
REQ-006 While hready=0, sel_q SHALL hold its value, which extends the data phase.
REQ-007 The outputs SHALL be combinational from sel_q and the slave inputs, with zero added latency:
- sel_q=001: slave-1 values on hrdata/hready/hresp.
- sel_q=010: slave-2 values.
- sel_q=100: slave-3 values, or default-slave values (REQ-012).
REQ-008 With sel_q=000, the outputs SHALL be hrdata=32'h0, hready=1, hresp=00.
REQ-009 Bits 31:2 of a selected hresp SHALL NOT exist; hresp SHALL pass through as 2 bits unmodified.

Reset
REQ-010 On hresetn low, independent of hclk and including mid-transfer, the block SHALL:
- set sel_q to 000;
- put the default-slave FSM in DS_IDLE;
- drive hrdata=0, hready=1, hresp=00 immediately.
REQ-011 After hresetn rises, the first hready=1 clock edge SHALL load sel_q normally.

Configuration
REQ-012 With macro CSI2TX_AHB_DEFAULT_SLAVE_EN defined, an internal default slave SHALL replace slave 3:
- The slave-3 inputs SHALL be ignored.
- The default slave is an FSM with states DS_IDLE, DS_ERR1, DS_ERR2.
REQ-013 Default-slave FSM transitions:
- Any state -> DS_ERR1 on an edge with hready=1, hsel3 winning per REQ-004, and htrans[1]=1.
- DS_ERR1 -> DS_ERR2 unconditionally.
- DS_ERR2 -> DS_IDLE otherwise.
REQ-014 Default-slave outputs by state:
- DS_IDLE: hready=1, hresp=00.
- DS_ERR1: hready=0, hresp=01.
- DS_ERR2: hready=1, hresp=01.
- hrdata SHALL be 32'h0 in all states.
REQ-015 An IDLE or BUSY transfer to hsel3 SHALL select the default slave with sel_q=100 but keep the FSM in DS_IDLE, giving a zero-wait OKAY.
REQ-016 Without CSI2TX_AHB_DEFAULT_SLAVE_EN:
- The FSM SHALL be absent.
- sel_q=100 SHALL route hrdata_s3/hreadyout_s3/hresp_s3.

Verification
REQ-017 The bench SHALL cover the following directed scenarios:
- Reset: hresetn=0 -> hready=1, hresp=00, hrdata=0; sel_q=000 with no clock needed.
- Read from slave 2: hsel2=1, htrans=10; next cycle hrdata_s2=32'hA5A5_0001, hreadyout_s2=1 -> hrdata=32'hA5A5_0001, hresp=00.
- Wait states: slave-1 transfer with hreadyout_s1=0 for 2 cycles, while hsel2=1 is presented -> sel_q stays 001 for 3 cycles, then becomes 010.
- Overlap: hsel1 and hsel2 both high at an hready=1 edge -> slave-2 data is routed.
- Error response (macro on): hsel3=1, htrans=10 -> next two cycles (hready,hresp) = (0,01) then (1,01), then FSM returns to DS_IDLE.
- Back-to-back errors and reset (macro on): a second NONSEQ to hsel3 accepted in DS_ERR2 -> DS_ERR1 again; hresetn pulse during DS_ERR1 -> hready=1, hresp=00 at once.
